ntt_masked_bf_seq: RTL and testbench

Issue/drain sequencer for the masked 1x2 butterfly datapath used in the first stage of masked INTT. On `start_i` it reads operand and twiddle words for a full polynomial pass, issues one butterfly per cycle, and tracks the fixed 264-cycle pipeline latency. It writes the unmasked, div2'd results back in order and pulses `done_o`. The datapath cannot stall, so all flow control happens at issue time.

---
 rtl/ntt_masked_bf_seq_if.sv | 33 +++
 rtl/ntt_masked_bf_seq.sv | 121 ++++++++++++
 tb/tb_ntt_masked_bf_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_masked_bf_seq_if.sv
// Issue/drain bus between the masked-butterfly sequencer and its environment.
// The slave modport is the sequencer side; the master modport is the controller/memory side.
interface ntt_masked_bf_seq_if #(
    parameter int ADDR_W = 15
);
    // A pass starts on start_i sampled in IDLE; strobes are single-cycle and never back-pressured.
    logic              start_i;
    logic [ADDR_W-1:0] src_base_i;
    logic [ADDR_W-1:0] dst_base_i;
    logic [ADDR_W-1:0] tw_base_i;
    logic              rnd_valid_i;
    logic              rnd_rd_o;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_rd_addr_o;
    logic [ADDR_W-1:0] tw_rd_addr_o;
    logic              bf_valid_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_wr_addr_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, src_base_i, dst_base_i, tw_base_i, rnd_valid_i,
        input  rnd_rd_o, mem_rd_en_o, mem_rd_addr_o, tw_rd_addr_o,
        input  bf_valid_o, mem_wr_en_o, mem_wr_addr_o, busy_o, done_o
    );

    modport slave (
        input  start_i, src_base_i, dst_base_i, tw_base_i, rnd_valid_i,
        output rnd_rd_o, mem_rd_en_o, mem_rd_addr_o, tw_rd_addr_o,
        output bf_valid_o, mem_wr_en_o, mem_wr_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/ntt_masked_bf_seq.sv
// Issue/drain sequencer for the masked 1x2 butterfly pipeline (fixed latency, no stall).
// Optional macro NTT_MASKED_BF_RND_STALL_EN: hold off issue while no fresh randomness is available.
module ntt_masked_bf_seq #(
    parameter int ADDR_W     = 15,
    parameter int NUM_BFLY   = 64,
    parameter int BF_LATENCY = 264,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  zeroize,
    ntt_masked_bf_seq_if.slave    bus,
    output logic [1:0]            dbg_state_o
);
    localparam int DL_W  = RD_LATENCY + BF_LATENCY;
    localparam int CNT_W = $clog2(NUM_BFLY + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BFLY);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] tw_base;
    logic [DL_W-1:0]   vld_dl;
    logic              rnd_ok;
    logic              issue_ok;

`ifdef NTT_MASKED_BF_RND_STALL_EN
    assign rnd_ok = bus.rnd_valid_i;
`else
    logic unused_rnd_valid;
    assign unused_rnd_valid = bus.rnd_valid_i;
    assign rnd_ok           = 1'b1;
`endif

    // The datapath cannot stall, so this is the only flow-control point.
    assign issue_ok    = (state == ISSUE) && (issue_cnt != LAST) && rnd_ok;
    assign bus.busy_o  = (state != IDLE);
    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            issue_cnt         <= '0;
            wr_cnt            <= '0;
            src_base          <= '0;
            dst_base          <= '0;
            tw_base           <= '0;
            vld_dl            <= '0;
            bus.rnd_rd_o      <= 1'b0;
            bus.mem_rd_en_o   <= 1'b0;
            bus.mem_rd_addr_o <= '0;
            bus.tw_rd_addr_o  <= '0;
            bus.bf_valid_o    <= 1'b0;
            bus.mem_wr_en_o   <= 1'b0;
            bus.mem_wr_addr_o <= '0;
            bus.done_o        <= 1'b0;
        end else if (zeroize) begin
            state             <= IDLE;
            issue_cnt         <= '0;
            wr_cnt            <= '0;
            src_base          <= '0;
            dst_base          <= '0;
            tw_base           <= '0;
            vld_dl            <= '0;
            bus.rnd_rd_o      <= 1'b0;
            bus.mem_rd_en_o   <= 1'b0;
            bus.mem_rd_addr_o <= '0;
            bus.tw_rd_addr_o  <= '0;
            bus.bf_valid_o    <= 1'b0;
            bus.mem_wr_en_o   <= 1'b0;
            bus.mem_wr_addr_o <= '0;
            bus.done_o        <= 1'b0;
        end else begin
            bus.mem_rd_en_o <= issue_ok;
            bus.rnd_rd_o    <= issue_ok;
            if (issue_ok) begin
                bus.mem_rd_addr_o <= src_base + ADDR_W'(issue_cnt);
                bus.tw_rd_addr_o  <= tw_base + ADDR_W'(issue_cnt);
                issue_cnt         <= issue_cnt + 1'b1;
            end

            // Bit k of the delay line is set k cycles after the issue that fed it.
            vld_dl          <= {vld_dl[DL_W-2:0], issue_ok};
            bus.bf_valid_o  <= vld_dl[RD_LATENCY-1];
            bus.mem_wr_en_o <= vld_dl[DL_W-1];
            if (vld_dl[DL_W-1]) begin
                bus.mem_wr_addr_o <= dst_base + ADDR_W'(wr_cnt);
                wr_cnt            <= wr_cnt + 1'b1;
            end

            bus.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        src_base  <= bus.src_base_i;
                        dst_base  <= bus.dst_base_i;
                        tw_base   <= bus.tw_base_i;
                        issue_cnt <= '0;
                        wr_cnt    <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_cnt == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (wr_cnt == LAST) begin
                        state      <= DONE;
                        bus.done_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_masked_bf_seq.sv
// Directed/randomized bench for ntt_masked_bf_seq: passes are logged by a monitor and
// compared against issue/write schedules derived from the pass rules.
module tb_ntt_masked_bf_seq;
    localparam int AW  = 15;
    localparam int NB  = 64;
    localparam int LAT = 265;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       zeroize = 1'b0;
    logic [1:0] dbg_state;

    ntt_masked_bf_seq_if #(.ADDR_W(AW)) bus ();

    ntt_masked_bf_seq #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .zeroize     (zeroize),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- randomness source driver ----------------
    int rnd_mode = 0;
    bit rnd_hist [int];
    always @(negedge clk) begin
        bit v;
        case (rnd_mode)
            0:       v = 1'b1;
            1:       v = ((cyc + 1) % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
        endcase
        bus.rnd_valid_i = v;
        rnd_hist[cyc + 1] = v;
    end

    // ---------------- monitor ----------------
    int             rd_cyc_q[$];
    logic [AW-1:0]  rd_addr_q[$];
    logic [AW-1:0]  tw_addr_q[$];
    int             rnd_cyc_q[$];
    int             bf_cyc_q[$];
    int             wr_cyc_q[$];
    logic [AW-1:0]  wr_addr_q[$];
    int             done_q[$];
    bit             busy_hist [int];

    always @(negedge clk) begin
        if (bus.mem_rd_en_o === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(bus.mem_rd_addr_o);
            tw_addr_q.push_back(bus.tw_rd_addr_o);
        end
        if (bus.rnd_rd_o === 1'b1) rnd_cyc_q.push_back(cyc);
        if (bus.bf_valid_o === 1'b1) bf_cyc_q.push_back(cyc);
        if (bus.mem_wr_en_o === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(bus.mem_wr_addr_o);
        end
        if (bus.done_o === 1'b1) done_q.push_back(cyc);
        busy_hist[cyc] = (bus.busy_o === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clr_logs();
        rd_cyc_q.delete(); rd_addr_q.delete(); tw_addr_q.delete(); rnd_cyc_q.delete();
        bf_cyc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); done_q.delete();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [50:0] all_outs();
        return {bus.rnd_rd_o, bus.mem_rd_en_o, bus.mem_rd_addr_o, bus.tw_rd_addr_o,
                bus.bf_valid_o, bus.mem_wr_en_o, bus.mem_wr_addr_o, bus.busy_o, bus.done_o};
    endfunction

    task automatic pulse_start(input logic [AW-1:0] src, dst, tw);
        bus.start_i    = 1'b1;
        bus.src_base_i = src;
        bus.dst_base_i = dst;
        bus.tw_base_i  = tw;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Returns the cycle whose rising edge samples the start.
    task automatic do_start(input logic [AW-1:0] src, dst, tw, output int t0);
        clr_logs();
        t0 = cyc + 1;
        pulse_start(src, dst, tw);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (done_q.size() == 0 && g < 3000) begin
            tick();
            g++;
        end
        chk({tag, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
        repeat (3) tick();
    endtask

    // ---------------- scoreboard / reference model ----------------
    task automatic check_pass(input string tag, input int t0, input logic [AW-1:0] src, dst, tw);
        int            iss[$];
        logic [AW-1:0] exp_q[$];
        int            c;
        int            dn;
        bit            ok;
        c = t0 + 1;
        while (iss.size() < NB && c < t0 + 4000) begin
`ifdef NTT_MASKED_BF_RND_STALL_EN
            ok = rnd_hist.exists(c) ? rnd_hist[c] : 1'b0;
`else
            ok = 1'b1;
`endif
            if (ok) iss.push_back(c);
            c++;
        end
        for (int k = 0; k < NB; k++) exp_q.push_back(dst + AW'(k));

        chk({tag, "_n_rd"},   64'(rd_cyc_q.size()),  64'(NB));
        chk({tag, "_n_rnd"},  64'(rnd_cyc_q.size()), 64'(NB));
        chk({tag, "_n_bf"},   64'(bf_cyc_q.size()),  64'(NB));
        chk({tag, "_n_wr"},   64'(wr_cyc_q.size()),  64'(NB));
        chk({tag, "_n_done"}, 64'(done_q.size()),    64'd1);
        for (int k = 0; k < NB && k < iss.size(); k++) begin
            if (k < rd_cyc_q.size()) begin
                chk($sformatf("%s_rd_cyc[%0d]", tag, k),  64'(rd_cyc_q[k]),  64'(iss[k]));
                chk($sformatf("%s_rd_addr[%0d]", tag, k), 64'(rd_addr_q[k]), 64'(AW'(src + AW'(k))));
                chk($sformatf("%s_tw_addr[%0d]", tag, k), 64'(tw_addr_q[k]), 64'(AW'(tw + AW'(k))));
            end
            if (k < rnd_cyc_q.size())
                chk($sformatf("%s_rnd_cyc[%0d]", tag, k), 64'(rnd_cyc_q[k]), 64'(iss[k]));
            if (k < bf_cyc_q.size())
                chk($sformatf("%s_bf_cyc[%0d]", tag, k), 64'(bf_cyc_q[k]), 64'(iss[k] + 1));
            if (k < wr_cyc_q.size()) begin
                chk($sformatf("%s_wr_cyc[%0d]", tag, k),  64'(wr_cyc_q[k]),  64'(iss[k] + LAT));
                chk($sformatf("%s_wr_addr[%0d]", tag, k), 64'(wr_addr_q[k]), 64'(exp_q[k]));
            end
        end
        if (iss.size() == NB && done_q.size() > 0) begin
            dn = iss[NB-1] + LAT + 1;
            chk({tag, "_done_cyc"}, 64'(done_q[0]), 64'(dn));
            chk({tag, "_busy_at_first_issue"}, 64'(busy_hist.exists(t0 + 1) && busy_hist[t0 + 1]), 64'd1);
            chk({tag, "_busy_after_done"}, 64'(busy_hist.exists(dn + 1) ? busy_hist[dn + 1] : 1'b1), 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            t0;
        logic [AW-1:0] s, d, w;

        bus.start_i     = 1'b0;
        bus.src_base_i  = '0;
        bus.dst_base_i  = '0;
        bus.tw_base_i   = '0;
        bus.rnd_valid_i = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("reset_outs_in_reset", 64'(all_outs()), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("reset_outs_after", 64'(all_outs()), 64'd0);
        chk("reset_state_idle", 64'(dbg_state), 64'd0);

        // Gap-free pass with the reference bases
        rnd_mode = 0;
        do_start(15'h100, 15'h200, 15'h040, t0);
        wait_done("gapfree");
        check_pass("gapfree", t0, 15'h100, 15'h200, 15'h040);
        if (done_q.size() > 0) chk("gapfree_done_t330", 64'(done_q[0] - t0), 64'd330);

        // Alternating randomness availability
        rnd_mode = 1;
        s = AW'($urandom_range(0, 32767));
        d = AW'($urandom_range(0, 32767));
        w = AW'($urandom_range(0, 32767));
        do_start(s, d, w, t0);
        wait_done("alt");
        check_pass("alt", t0, s, d, w);

        // Starts during ISSUE and DRAIN are ignored
        rnd_mode = 0;
        do_start(15'h300, 15'h500, 15'h020, t0);
        run_to(t0 + 20);
        pulse_start(15'h111, 15'h222, 15'h333);
        run_to(t0 + 150);
        pulse_start(15'h444, 15'h555, 15'h666);
        wait_done("restart");
        check_pass("restart", t0, 15'h300, 15'h500, 15'h020);

        // Zeroize mid-DRAIN, then a clean pass
        do_start(15'h010, 15'h020, 15'h030, t0);
        run_to(t0 + 99);
        zeroize = 1'b1;
        tick();
        chk("zeroize_outs", 64'(all_outs()), 64'd0);
        chk("zeroize_state", 64'(dbg_state), 64'd0);
        zeroize = 1'b0;
        clr_logs();
        repeat (300) tick();
        chk("zeroize_no_writes", 64'(wr_cyc_q.size()), 64'd0);
        chk("zeroize_no_done", 64'(done_q.size()), 64'd0);
        rnd_mode = 2;
        s = AW'($urandom_range(0, 32767));
        d = AW'($urandom_range(0, 32767));
        w = AW'($urandom_range(0, 32767));
        do_start(s, d, w, t0);
        wait_done("post_zeroize");
        check_pass("post_zeroize", t0, s, d, w);

        // Address wrap on destination and source
        do_start(15'h7FE0, 15'h7FF0, 15'h7FC8, t0);
        wait_done("wrap");
        check_pass("wrap", t0, 15'h7FE0, 15'h7FF0, 15'h7FC8);
        if (wr_addr_q.size() == NB) begin
            chk("wrap_wr16", 64'(wr_addr_q[16]), 64'h0000);
            chk("wrap_wr63", 64'(wr_addr_q[63]), 64'h002F);
        end

        // Asynchronous reset mid-ISSUE
        rnd_mode = 0;
        do_start(15'h100, 15'h200, 15'h040, t0);
        run_to(t0 + 10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", 64'(all_outs()), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("async_reset_state", 64'(dbg_state), 64'd0);
        chk("async_reset_outs_after", 64'(all_outs()), 64'd0);

        // Random pass after reset recovery
        rnd_mode = 2;
        s = AW'($urandom_range(0, 32767));
        d = AW'($urandom_range(0, 32767));
        w = AW'($urandom_range(0, 32767));
        do_start(s, d, w, t0);
        wait_done("final");
        check_pass("final", t0, s, d, w);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
